cdma_lite_slave: RTL and testbench
==================================

Name: cdma_lite_slave

Overview:
- AXI4-Lite responder that emulates the CDMA simple-mode register map: CDMACR, CDMASR, SA, DA and BTT.
- A write to BTT while idle launches one transfer to a local datamover through a start/done pulse pair.
- Status, including idle and interrupt-on-complete, is readable back over the same AXI-Lite port.
- Used as the target end of the CDMA-programming master, so that master can be exercised and its datamover substituted in simulation or on fabric.

Parameters:
- DATA_WIDTH, 32, AXI-Lite data width (only 32 supported).
- ADDR_WIDTH, 32, AXI-Lite address width; only addr[7:2] is decoded.
- BTT_WIDTH, 23, width of the bytes-to-transfer field.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- S_AXI_LITE_awaddr  in  ADDR_WIDTH  write address
- S_AXI_LITE_awvalid  in  1  write address valid
- S_AXI_LITE_awready  out  1  write address ready
- S_AXI_LITE_wdata  in  DATA_WIDTH  write data (full-word writes only, no strobes)
- S_AXI_LITE_wvalid  in  1  write data valid
- S_AXI_LITE_wready  out  1  write data ready
- S_AXI_LITE_bresp  out  2  write response
- S_AXI_LITE_bvalid  out  1  write response valid
- S_AXI_LITE_bready  in  1  write response ready
- S_AXI_LITE_araddr  in  ADDR_WIDTH  read address
- S_AXI_LITE_arvalid  in  1  read address valid
- S_AXI_LITE_arready  out  1  read address ready
- S_AXI_LITE_rdata  out  DATA_WIDTH  read data
- S_AXI_LITE_rresp  out  2  read response
- S_AXI_LITE_rvalid  out  1  read data valid
- S_AXI_LITE_rready  in  1  read data ready
- xfer_start  out  1  one-cycle transfer launch pulse
- xfer_src  out  ADDR_WIDTH  source address (SA register)
- xfer_dst  out  ADDR_WIDTH  destination address (DA register)
- xfer_len  out  BTT_WIDTH  byte count (BTT register)
- xfer_done  in  1  one-cycle completion pulse from the datamover
- irq  out  1  interrupt output = CDMASR.IOC_Irq & CDMACR.IOC_IrqEn

Behaviour:
- Reset (rst_n low, asynchronous):
  - All ready/valid outputs 0; bresp and rresp 2'b00; rdata 0; xfer_start 0.
  - All registers 0 except busy=0, so CDMASR.Idle (bit1) reads 1; irq 0.
  - Reset mid-transfer abandons the transfer; a later xfer_done pulse with busy=0 is ignored.
- Register map (byte offsets):
  - 0x00 CDMACR: RW, 32 bits, bit12 = IOC_IrqEn.
  - 0x04 CDMASR: bit1 Idle (RO, = ~busy); bit12 IOC_Irq (write-1-to-clear); all other bits read 0.
  - 0x18 SA: RW.
  - 0x20 DA: RW.
  - 0x28 BTT: RW, bits [BTT_WIDTH-1:0]; upper bits read 0.
  - Unmapped offsets: reads return 0 with OKAY; writes are dropped with OKAY.
- Write channel FSM:
  - States: W_IDLE, W_EXEC, W_RESP.
  - awready and wready are each high in W_IDLE until their own beat is captured. AW and W are accepted in either order or in the same cycle.
  - When both beats are held, go to W_EXEC (1 cycle): the register update takes effect, then go to W_RESP.
  - In W_RESP, bvalid=1 and stays held until bready; then return to W_IDLE.
  - Minimum latency: AW/W handshake cycle N, bvalid in cycle N+2.
- BTT write:
  - Busy (busy=1 at the start of the W_EXEC cycle): BTT is unchanged, no launch, bresp=SLVERR (2'b10). This applies even if xfer_done arrives in that same cycle.
  - Idle and data[BTT_WIDTH-1:0] != 0: latch BTT, set busy, pulse xfer_start for exactly 1 cycle (the cycle after W_EXEC). xfer_src, xfer_dst and xfer_len are valid from the xfer_start cycle until xfer_done.
  - Idle and BTT=0: register takes 0, no launch, bresp=OKAY.
- SA/DA writes while busy: the register updates, but xfer_src and xfer_dst stay at the values snapshotted at launch.
- xfer_done while busy: clear busy and set IOC_Irq. If a W1C write of IOC_Irq lands in the same cycle, the set wins.
- Read channel:
  - arready = ~rvalid.
  - On AR handshake at cycle N: rdata registered, rvalid=1 at N+1, held with stable data until rready.
  - A read and a write executing in the same cycle: the read returns the pre-write value.
  - rresp is always OKAY.
- irq is registered from the register bits (1-cycle delay after IOC_Irq sets).

Decomposition:
- Shared package cdma_pkg holds:
  - register offset localparams (CDMACR_OFF=0x00, CDMASR_OFF=0x04, SA_OFF=0x18, DA_OFF=0x20, BTT_OFF=0x28);
  - bit indices IDLE_BIT=1, IOC_IRQ_BIT=12;
  - RESP_OKAY and RESP_SLVERR.
- No sub-modules; the write FSM, read path and register file all sit in one module.

Test Plan:
- Write CDMACR=0, SA=0x1000_0000, DA=0x2000_0000, BTT=0x400, each with AW and W in the same cycle -> every bresp OKAY with bvalid 2 cycles after the handshake; one xfer_start pulse with xfer_src=0x1000_0000, xfer_dst=0x2000_0000, xfer_len=0x400; a CDMASR read returns Idle=0.
- W beat presented 3 cycles before AW, then AW 2 cycles before W on the next write -> both writes commit correctly and wready/awready drop after their own capture.
- With CDMACR=0x1000, pulse xfer_done -> CDMASR reads 0x1002 and irq=1; write CDMASR=0x1000 -> reads 0x0002 and irq=0.
- BTT write while busy -> bresp=SLVERR, BTT readback unchanged, no xfer_start; BTT=0 while idle -> OKAY and no xfer_start.
- Read offset 0x3C -> rdata=0, OKAY; hold rready low 4 cycles -> rvalid and rdata stable and arready=0 throughout.
- Drop rst_n mid-transfer -> all outputs reach reset values immediately; a subsequent xfer_done is ignored; CDMASR reads 0x0002.

Source files
------------

// File: rtl/cdma_pkg.sv
// Shared definitions for the CDMA-lite register responder: register offsets,
// status bit positions, AXI response codes and the write-channel state type.
package cdma_pkg;

  localparam logic [7:0] CDMACR_OFF = 8'h00;
  localparam logic [7:0] CDMASR_OFF = 8'h04;
  localparam logic [7:0] SA_OFF     = 8'h18;
  localparam logic [7:0] DA_OFF     = 8'h20;
  localparam logic [7:0] BTT_OFF    = 8'h28;

  localparam int IDLE_BIT    = 1;
  localparam int IOC_IRQ_BIT = 12;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_EXEC = 2'd1,
    W_RESP = 2'd2
  } wstate_e;

  function automatic logic [5:0] word_idx(input logic [7:0] off);
    return off[7:2];
  endfunction

endpackage

// File: rtl/cdma_lite_slave.sv
// AXI4-Lite target emulating the CDMA simple-mode register map; a BTT write
// while idle launches one transfer to a local datamover via xfer_start/xfer_done.
module cdma_lite_slave
  import cdma_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BTT_WIDTH  = 23
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] S_AXI_LITE_awaddr,
  input  logic                  S_AXI_LITE_awvalid,
  output logic                  S_AXI_LITE_awready,
  input  logic [DATA_WIDTH-1:0] S_AXI_LITE_wdata,
  input  logic                  S_AXI_LITE_wvalid,
  output logic                  S_AXI_LITE_wready,
  output logic [1:0]            S_AXI_LITE_bresp,
  output logic                  S_AXI_LITE_bvalid,
  input  logic                  S_AXI_LITE_bready,
  input  logic [ADDR_WIDTH-1:0] S_AXI_LITE_araddr,
  input  logic                  S_AXI_LITE_arvalid,
  output logic                  S_AXI_LITE_arready,
  output logic [DATA_WIDTH-1:0] S_AXI_LITE_rdata,
  output logic [1:0]            S_AXI_LITE_rresp,
  output logic                  S_AXI_LITE_rvalid,
  input  logic                  S_AXI_LITE_rready,
  output logic                  xfer_start,
  output logic [ADDR_WIDTH-1:0] xfer_src,
  output logic [ADDR_WIDTH-1:0] xfer_dst,
  output logic [BTT_WIDTH-1:0]  xfer_len,
  input  logic                  xfer_done,
  output logic                  irq
);

  localparam logic [5:0] CR_IDX  = word_idx(CDMACR_OFF);
  localparam logic [5:0] SR_IDX  = word_idx(CDMASR_OFF);
  localparam logic [5:0] SA_IDX  = word_idx(SA_OFF);
  localparam logic [5:0] DA_IDX  = word_idx(DA_OFF);
  localparam logic [5:0] BTT_IDX = word_idx(BTT_OFF);

  wstate_e               wstate_q;
  logic                  awready_q, wready_q, aw_held_q, w_held_q, bvalid_q;
  logic [1:0]            bresp_q;
  logic [5:0]            awidx_q;
  logic [DATA_WIDTH-1:0] wdata_q, cr_q, rdata_q;
  logic [ADDR_WIDTH-1:0] sa_q, da_q, src_q, dst_q;
  logic [BTT_WIDTH-1:0]  btt_q;
  logic                  busy_q, ioc_q, start_q, irq_q, arready_q, rvalid_q;

  logic                  aw_hs_s, w_hs_s, ar_hs_s, aw_held_d, w_held_d;
  logic                  exec_s, btt_wr_s, launch_s, sr_clr_s, done_s, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  unused_s;

  assign unused_s = ^{S_AXI_LITE_awaddr[ADDR_WIDTH-1:8], S_AXI_LITE_awaddr[1:0],
                      S_AXI_LITE_araddr[ADDR_WIDTH-1:8], S_AXI_LITE_araddr[1:0]};

  always_comb begin
    aw_hs_s   = S_AXI_LITE_awvalid & awready_q;
    w_hs_s    = S_AXI_LITE_wvalid & wready_q;
    ar_hs_s   = S_AXI_LITE_arvalid & arready_q;
    aw_held_d = aw_held_q | aw_hs_s;
    w_held_d  = w_held_q | w_hs_s;
    exec_s    = (wstate_q == W_EXEC);
    btt_wr_s  = exec_s & (awidx_q == BTT_IDX);
    // busy is sampled at the start of the execute cycle, so a coincident done still rejects
    launch_s  = btt_wr_s & ~busy_q & (wdata_q[BTT_WIDTH-1:0] != {BTT_WIDTH{1'b0}});
    sr_clr_s  = exec_s & (awidx_q == SR_IDX) & wdata_q[IOC_IRQ_BIT];
    done_s    = xfer_done & busy_q;
    if (rvalid_q) begin
      rvalid_d = ~S_AXI_LITE_rready;
    end else begin
      rvalid_d = ar_hs_s;
    end
    rdata_d = {DATA_WIDTH{1'b0}};
    case (S_AXI_LITE_araddr[7:2])
      CR_IDX: rdata_d = cr_q;
      SR_IDX: begin
        rdata_d[IOC_IRQ_BIT] = ioc_q;
        rdata_d[IDLE_BIT]    = ~busy_q;
      end
      SA_IDX:  rdata_d = DATA_WIDTH'(sa_q);
      DA_IDX:  rdata_d = DATA_WIDTH'(da_q);
      BTT_IDX: rdata_d = DATA_WIDTH'(btt_q);
      default: rdata_d = {DATA_WIDTH{1'b0}};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awidx_q   <= 6'd0;
      wdata_q   <= {DATA_WIDTH{1'b0}};
    end else begin
      case (wstate_q)
        W_IDLE: begin
          if (aw_hs_s) awidx_q <= S_AXI_LITE_awaddr[7:2];
          if (w_hs_s)  wdata_q <= S_AXI_LITE_wdata;
          if (aw_held_d && w_held_d) begin
            wstate_q  <= W_EXEC;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
          end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awready_q <= ~aw_held_d;
            wready_q  <= ~w_held_d;
          end
        end
        W_EXEC: begin
          wstate_q <= W_RESP;
          bvalid_q <= 1'b1;
          bresp_q  <= (btt_wr_s && busy_q) ? RESP_SLVERR : RESP_OKAY;
        end
        W_RESP: begin
          if (S_AXI_LITE_bready) begin
            wstate_q  <= W_IDLE;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: begin
          wstate_q <= W_IDLE;
          bvalid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr_q    <= {DATA_WIDTH{1'b0}};
      sa_q    <= {ADDR_WIDTH{1'b0}};
      da_q    <= {ADDR_WIDTH{1'b0}};
      btt_q   <= {BTT_WIDTH{1'b0}};
      src_q   <= {ADDR_WIDTH{1'b0}};
      dst_q   <= {ADDR_WIDTH{1'b0}};
      busy_q  <= 1'b0;
      ioc_q   <= 1'b0;
      start_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      start_q <= launch_s;
      irq_q   <= ioc_q & cr_q[IOC_IRQ_BIT];
      if (exec_s) begin
        case (awidx_q)
          CR_IDX:  cr_q <= wdata_q;
          SA_IDX:  sa_q <= wdata_q[ADDR_WIDTH-1:0];
          DA_IDX:  da_q <= wdata_q[ADDR_WIDTH-1:0];
          BTT_IDX: if (!busy_q) btt_q <= wdata_q[BTT_WIDTH-1:0];
          default: ;
        endcase
      end
      // outputs to the datamover are snapshots, so later SA/DA writes leave them untouched
      if (launch_s) begin
        busy_q <= 1'b1;
        src_q  <= sa_q;
        dst_q  <= da_q;
      end else if (done_s) begin
        busy_q <= 1'b0;
      end
      if (done_s) begin
        ioc_q <= 1'b1;
      end else if (sr_clr_s) begin
        ioc_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rdata_q   <= {DATA_WIDTH{1'b0}};
    end else begin
      rvalid_q  <= rvalid_d;
      arready_q <= ~rvalid_d;
      if (ar_hs_s) rdata_q <= rdata_d;
    end
  end

  assign S_AXI_LITE_awready = awready_q;
  assign S_AXI_LITE_wready  = wready_q;
  assign S_AXI_LITE_bvalid  = bvalid_q;
  assign S_AXI_LITE_bresp   = bresp_q;
  assign S_AXI_LITE_arready = arready_q;
  assign S_AXI_LITE_rvalid  = rvalid_q;
  assign S_AXI_LITE_rdata   = rdata_q;
  assign S_AXI_LITE_rresp   = RESP_OKAY;
  assign xfer_start         = start_q;
  assign xfer_src           = src_q;
  assign xfer_dst           = dst_q;
  assign xfer_len           = btt_q;
  assign irq                = irq_q;

endmodule

// File: tb/tb_cdma_lite_slave.sv
// Self-checking bench for cdma_lite_slave: table vectors, directed transfer/irq/reset
// sequences and randomized traffic checked against a behavioural register-map model.
module tb_cdma_lite_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] awaddr = 32'd0, wdata = 32'd0, araddr = 32'd0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, xfer_src, xfer_dst;
  logic [22:0] xfer_len;
  logic        xfer_start, irq;
  logic        xfer_done = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  // behavioural model of the register map
  logic [31:0] m_cr = 32'd0, m_sa = 32'd0, m_da = 32'd0, e_src = 32'd0, e_dst = 32'd0;
  logic [22:0] m_btt = 23'd0, e_len = 23'd0;
  bit          m_busy = 1'b0, m_ioc = 1'b0;
  int          m_starts = 0;

  int          start_cnt = 0;
  logic [31:0] c_src = 32'd0, c_dst = 32'd0;
  logic [22:0] c_len = 23'd0;

  cdma_lite_slave dut (
    .clk(clk), .rst_n(rst_n),
    .S_AXI_LITE_awaddr(awaddr), .S_AXI_LITE_awvalid(awvalid), .S_AXI_LITE_awready(awready),
    .S_AXI_LITE_wdata(wdata), .S_AXI_LITE_wvalid(wvalid), .S_AXI_LITE_wready(wready),
    .S_AXI_LITE_bresp(bresp), .S_AXI_LITE_bvalid(bvalid), .S_AXI_LITE_bready(bready),
    .S_AXI_LITE_araddr(araddr), .S_AXI_LITE_arvalid(arvalid), .S_AXI_LITE_arready(arready),
    .S_AXI_LITE_rdata(rdata), .S_AXI_LITE_rresp(rresp), .S_AXI_LITE_rvalid(rvalid),
    .S_AXI_LITE_rready(rready),
    .xfer_start(xfer_start), .xfer_src(xfer_src), .xfer_dst(xfer_dst), .xfer_len(xfer_len),
    .xfer_done(xfer_done), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (xfer_start === 1'b1) begin
      start_cnt <= start_cnt + 1;
      c_src <= xfer_src;
      c_dst <= xfer_dst;
      c_len <= xfer_len;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] off;
    off = a & 32'h0000_00FC;
    if (off == 32'h00) return m_cr;
    if (off == 32'h04) return (m_ioc ? 32'h1000 : 32'h0) + (m_busy ? 32'h0 : 32'h2);
    if (off == 32'h18) return m_sa;
    if (off == 32'h20) return m_da;
    if (off == 32'h28) return {9'd0, m_btt};
    return 32'd0;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                      output logic [1:0] resp, output bit launch);
    logic [31:0] off;
    off = a & 32'h0000_00FC;
    resp = 2'b00;
    launch = 1'b0;
    if (off == 32'h00) m_cr = d;
    else if (off == 32'h04) begin
      if (d[12]) m_ioc = 1'b0;
    end
    else if (off == 32'h18) m_sa = d;
    else if (off == 32'h20) m_da = d;
    else if (off == 32'h28) begin
      if (m_busy) resp = 2'b10;
      else begin
        m_btt = d[22:0];
        if (m_btt != 23'd0) begin
          launch = 1'b1;
          m_busy = 1'b1;
          m_starts++;
          e_src = m_sa;
          e_dst = m_da;
          e_len = m_btt;
        end
      end
    end
  endfunction

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input int awd,
                           input int wd, output logic [1:0] resp);
    bit aw_done = 1'b0, w_done = 1'b0;
    int cyc = 0;
    int k = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      @(negedge clk);
      if (aw_done) check("awready_after_capture", 32'(awready), 32'd0);
      if (w_done) check("wready_after_capture", 32'(wready), 32'd0);
      awvalid = !aw_done && (cyc >= awd);
      awaddr  = a;
      wvalid  = !w_done && (cyc >= wd);
      wdata   = d;
      if (awvalid && awready) aw_done = 1'b1;
      if (wvalid && wready) w_done = 1'b1;
      cyc++;
    end
    if (!(aw_done && w_done)) check("write_handshake_timeout", 32'd1, 32'd0);
    do begin
      @(negedge clk);
      awvalid = 1'b0;
      wvalid = 1'b0;
      k++;
    end while (!bvalid && k < 20);
    check("bvalid_latency", 32'(k), 32'd2);
    resp = bresp;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input string nm, input logic [31:0] a, input int hold,
                          input logic [31:0] exp);
    int k = 0;
    @(negedge clk);
    arvalid = 1'b1;
    araddr = a;
    while (!arready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) check({nm, "_ar_timeout"}, 32'd1, 32'd0);
    @(negedge clk);
    arvalid = 1'b0;
    check({nm, "_rvalid"}, 32'(rvalid), 32'd1);
    check({nm, "_rdata"}, rdata, exp);
    check({nm, "_rresp"}, 32'(rresp), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({nm, "_hold_rvalid"}, 32'(rvalid), 32'd1);
      check({nm, "_hold_rdata"}, rdata, exp);
      check({nm, "_hold_arready"}, 32'(arready), 32'd0);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic do_write(input string nm, input logic [31:0] a, input logic [31:0] d,
                          input int awd, input int wd, output logic [1:0] resp);
    logic [1:0] exp_resp;
    bit launch;
    model_write(a, d, exp_resp, launch);
    axi_write(a, d, awd, wd, resp);
    @(negedge clk);
    check({nm, "_bresp"}, 32'(resp), 32'(exp_resp));
    check({nm, "_start_count"}, 32'(start_cnt), 32'(m_starts));
    if (launch) begin
      check({nm, "_xfer_src"}, c_src, e_src);
      check({nm, "_xfer_dst"}, c_dst, e_dst);
      check({nm, "_xfer_len"}, 32'(c_len), 32'(e_len));
    end
    if (m_busy) begin
      check({nm, "_src_held"}, xfer_src, e_src);
      check({nm, "_dst_held"}, xfer_dst, e_dst);
    end
    check({nm, "_irq"}, 32'(irq), 32'(m_ioc & m_cr[12]));
  endtask

  task automatic do_done();
    @(negedge clk);
    xfer_done = 1'b1;
    if (m_busy) begin
      m_busy = 1'b0;
      m_ioc = 1'b1;
    end
    @(negedge clk);
    xfer_done = 1'b0;
    @(negedge clk);
    check("irq_after_done", 32'(irq), 32'(m_ioc & m_cr[12]));
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_awready"}, 32'(awready), 32'd0);
    check({nm, "_wready"}, 32'(wready), 32'd0);
    check({nm, "_bvalid"}, 32'(bvalid), 32'd0);
    check({nm, "_bresp"}, 32'(bresp), 32'd0);
    check({nm, "_arready"}, 32'(arready), 32'd0);
    check({nm, "_rvalid"}, 32'(rvalid), 32'd0);
    check({nm, "_rdata"}, rdata, 32'd0);
    check({nm, "_rresp"}, 32'(rresp), 32'd0);
    check({nm, "_xfer_start"}, 32'(xfer_start), 32'd0);
    check({nm, "_xfer_len"}, 32'(xfer_len), 32'd0);
    check({nm, "_irq"}, 32'(irq), 32'd0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          awd;
    int          wd;
    logic [1:0]  resp;
    logic [31:0] rb;
  } vec_t;

  vec_t tbl[7];
  logic [7:0] offs[8];

  initial begin
    logic [1:0] resp;
    int sc;
    tbl[0] = '{32'h0000_0000, 32'h0000_1000, 0, 0, 2'b00, 32'h0000_1000};
    tbl[1] = '{32'h0000_0018, 32'h1234_5678, 3, 0, 2'b00, 32'h1234_5678};
    tbl[2] = '{32'h0000_0020, 32'h9ABC_DEF0, 0, 2, 2'b00, 32'h9ABC_DEF0};
    tbl[3] = '{32'h0000_0028, 32'hFF80_0000, 1, 1, 2'b00, 32'h0000_0000};
    tbl[4] = '{32'h0000_0004, 32'hFFFF_FFFF, 0, 0, 2'b00, 32'h0000_0002};
    tbl[5] = '{32'h0000_003C, 32'hDEAD_BEEF, 0, 0, 2'b00, 32'h0000_0000};
    tbl[6] = '{32'hFFFF_FF20, 32'h0000_0055, 0, 1, 2'b00, 32'h0000_0055};
    offs = '{8'h00, 8'h04, 8'h18, 8'h20, 8'h28, 8'h3C, 8'h08, 8'hFC};

    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    axi_read("rst_sr", 32'h04, 0, 32'h0000_0002);

    for (int i = 0; i < 7; i++) begin
      do_write($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].data, tbl[i].awd, tbl[i].wd, resp);
      check($sformatf("tbl%0d_resp", i), 32'(resp), 32'(tbl[i].resp));
      axi_read($sformatf("tbl%0d_rb", i), tbl[i].addr, 0, tbl[i].rb);
    end

    // launch a transfer with every beat pair presented together
    do_write("cr0", 32'h00, 32'h0000_0000, 0, 0, resp);
    do_write("sa", 32'h18, 32'h1000_0000, 0, 0, resp);
    do_write("da", 32'h20, 32'h2000_0000, 0, 0, resp);
    sc = start_cnt;
    do_write("btt", 32'h28, 32'h0000_0400, 0, 0, resp);
    check("launch_one_pulse", 32'(start_cnt), 32'(sc + 1));
    check("launch_src", c_src, 32'h1000_0000);
    check("launch_dst", c_dst, 32'h2000_0000);
    check("launch_len", 32'(c_len), 32'h400);
    axi_read("busy_sr", 32'h04, 0, 32'h0000_0000);

    do_write("btt_busy", 32'h28, 32'h0000_0123, 0, 0, resp);
    check("btt_busy_slverr", 32'(resp), 32'h2);
    axi_read("btt_busy_rb", 32'h28, 0, 32'h0000_0400);
    do_write("sa_busy", 32'h18, 32'h3000_0000, 0, 0, resp);
    check("sa_busy_src_snapshot", xfer_src, 32'h1000_0000);

    do_write("cr_ien", 32'h00, 32'h0000_1000, 0, 0, resp);
    do_done();
    axi_read("ioc_sr", 32'h04, 0, 32'h0000_1002);
    check("irq_set", 32'(irq), 32'd1);
    do_write("w1c", 32'h04, 32'h0000_1000, 0, 0, resp);
    axi_read("w1c_sr", 32'h04, 0, 32'h0000_0002);
    check("irq_clear", 32'(irq), 32'd0);

    sc = start_cnt;
    do_write("btt_zero", 32'h28, 32'h0000_0000, 0, 0, resp);
    check("btt_zero_okay", 32'(resp), 32'h0);
    check("btt_zero_no_start", 32'(start_cnt), 32'(sc));

    axi_read("unmapped_hold", 32'h3C, 4, 32'h0000_0000);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] r, a, d;
      int op;
      op = $urandom_range(0, 9);
      r = $urandom();
      a = {r[31:8], offs[$urandom_range(0, 7)]};
      d = $urandom();
      if ((a & 32'hFC) == 32'h28) d = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 5000));
      if (op < 5) do_write("rnd_wr", a, d, $urandom_range(0, 3), $urandom_range(0, 3), resp);
      else if (op < 8) axi_read("rnd_rd", a, $urandom_range(0, 2), model_read(a));
      else do_done();
    end

    // abandon a transfer through reset
    if (!m_busy) do_write("pre_rst_btt", 32'h28, 32'h0000_0080, 0, 0, resp);
    sc = start_cnt;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    m_cr = 32'd0; m_sa = 32'd0; m_da = 32'd0; m_btt = 23'd0; m_busy = 1'b0; m_ioc = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_done();
    check("midrst_irq", 32'(irq), 32'd0);
    axi_read("midrst_sr", 32'h04, 0, 32'h0000_0002);
    check("midrst_no_start", 32'(start_cnt), 32'(sc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
